// File: rtl/combo_lock_seq.sv
`default_nettype none
// ============================================================================
// Module   : combo_lock_seq
// Purpose  : Clocked keypad combination lock. Stores a CODE_LEN-digit code,
//            checks full-length attempts, counts consecutive failures with a
//            timed lockout, and abandons stalled attempts after an idle
//            timeout.
// Ports    : clk, reset      - clock (rising edge), synchronous active-high
//            key_in          - encoded key, 0 = no key
//            relock          - UNLOCKED -> ARMED
//            clear_code      - UNLOCKED -> PROGRAM, code erased
//            unlock          - high in UNLOCKED
//            locked_out      - high in LOCKOUT
//            programmed      - high when a code is stored
//            digit_count     - digits accepted in current sequence
//            fail_count      - consecutive failed attempts
// Revision : 1.0 - initial release
// ============================================================================
module combo_lock_seq #(
    parameter int DIGIT_W        = 4,
    parameter int CODE_LEN       = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DIGIT_W-1:0]                key_in,
    input  logic                              relock,
    input  logic                              clear_code,
    output logic                              unlock,
    output logic                              locked_out,
    output logic                              programmed,
    output logic [$clog2(CODE_LEN+1)-1:0]     digit_count,
    output logic [$clog2(MAX_FAILS+1)-1:0]    fail_count
);

    localparam int c_IDX_W  = $clog2(CODE_LEN + 1);
    localparam int c_SEL_W  = $clog2(CODE_LEN);
    localparam int c_FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int c_LK_W   = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int c_TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(CODE_LEN - 1);
    localparam logic [c_FAIL_W-1:0] c_FAIL_LAST = c_FAIL_W'(MAX_FAILS - 1);
    localparam logic [c_FAIL_W-1:0] c_FAIL_MAX  = c_FAIL_W'(MAX_FAILS);
    localparam logic [c_LK_W-1:0]   c_LK_START  = c_LK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam bit                  c_TO_EN     = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] c_ST_PROGRAM  = 2'd0;
    localparam logic [1:0] c_ST_ARMED    = 2'd1;
    localparam logic [1:0] c_ST_UNLOCKED = 2'd2;
    localparam logic [1:0] c_ST_LOCKOUT  = 2'd3;

    logic [1:0]          r_state;
    logic [DIGIT_W-1:0]  r_code [CODE_LEN];
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_FAIL_W-1:0] r_fails;
    logic [c_LK_W-1:0]   r_lock_tmr;
    logic [c_TO_W-1:0]   r_idle_cnt;
    logic                r_mismatch;
    logic                r_key_idle;

    logic                w_press;
    logic [c_SEL_W-1:0]  w_sel;
    logic                w_mis_next;
    logic                w_last_digit;

    // A press is the first cycle of a nonzero key after a cycle with no key.
    assign w_press      = (key_in != '0) && r_key_idle;
    // r_idx never exceeds CODE_LEN-1 while a code digit is being addressed.
    assign w_sel        = r_idx[c_SEL_W-1:0];
    assign w_mis_next   = r_mismatch | (key_in != r_code[w_sel]);
    assign w_last_digit = (r_idx == c_IDX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_PROGRAM;
            for (int i = 0; i < CODE_LEN; i++) r_code[i] <= '0;
            r_idx      <= '0;
            r_fails    <= '0;
            r_lock_tmr <= '0;
            r_idle_cnt <= '0;
            r_mismatch <= 1'b0;
            r_key_idle <= 1'b1;
        end else begin
            // Re-armed only by a cycle with no key; a press always clears it,
            // and a held or directly changed key keeps it clear.
            r_key_idle <= (key_in == '0);

            case (r_state)
                c_ST_PROGRAM: begin
                    if (w_press) begin
                        r_code[w_sel] <= key_in;
                        if (w_last_digit) begin
                            r_idx   <= '0;
                            r_state <= c_ST_ARMED;
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end
                end

                c_ST_ARMED: begin
                    if (w_press) begin
                        r_idle_cnt <= '0;
                        if (w_last_digit) begin
                            r_idx      <= '0;
                            r_mismatch <= 1'b0;
                            if (!w_mis_next) begin
                                r_state <= c_ST_UNLOCKED;
                                r_fails <= '0;
                            end else if (r_fails == c_FAIL_LAST) begin
                                r_state    <= c_ST_LOCKOUT;
                                r_lock_tmr <= c_LK_START;
                                r_fails    <= c_FAIL_MAX;
                            end else begin
                                r_fails <= r_fails + c_FAIL_W'(1);
                            end
                        end else begin
                            r_idx      <= r_idx + c_IDX_W'(1);
                            r_mismatch <= w_mis_next;
                        end
                    end else if (c_TO_EN && (r_idx != '0)) begin
                        // Partial attempt stalled: drop it, keep the fail tally.
                        if (r_idle_cnt == c_TO_LAST) begin
                            r_idx      <= '0;
                            r_mismatch <= 1'b0;
                            r_idle_cnt <= '0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + c_TO_W'(1);
                        end
                    end
                end

                c_ST_UNLOCKED: begin
                    if (clear_code) begin
                        for (int i = 0; i < CODE_LEN; i++) r_code[i] <= '0;
                        r_state <= c_ST_PROGRAM;
                    end else if (relock) begin
                        r_state <= c_ST_ARMED;
                    end
                end

                c_ST_LOCKOUT: begin
                    // Entered with LOCKOUT_CYCLES-1 so the state lasts exactly
                    // LOCKOUT_CYCLES cycles including the exit cycle.
                    if (r_lock_tmr == '0) begin
                        r_state <= c_ST_ARMED;
                        r_fails <= '0;
                    end else begin
                        r_lock_tmr <= r_lock_tmr - c_LK_W'(1);
                    end
                end

                default: r_state <= c_ST_PROGRAM;
            endcase
        end
    end

    assign unlock      = (r_state == c_ST_UNLOCKED);
    assign locked_out  = (r_state == c_ST_LOCKOUT);
    assign programmed  = (r_state != c_ST_PROGRAM);
    assign digit_count = r_idx;
    assign fail_count  = r_fails;

endmodule
`default_nettype wire

// File: doc/combo_lock_seq.md
Name: combo_lock_seq

Overview:
- Clocked, parametrised keypad combination lock; successor to the team's 4-digit combinational lock.
- Programs a CODE_LEN-digit code, then checks full-length attempts and drives the unlock output.
- Adds per-press edge detection, full-attempt comparison, failed-attempt counting with timed lockout, and an inter-digit timeout.
- Sits between the keypad encoder (key_in, 0 = no key) and the actuator/status logic.

Parameters:
- DIGIT_W, 4, width of key code; 0 means no key pressed.
- CODE_LEN, 4, digits per code; must be 2 or more.
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout; must be 1 or more.
- LOCKOUT_CYCLES, 16, clock cycles spent in lockout; must be 1 or more.
- TIMEOUT_CYCLES, 64, idle cycles mid-attempt before the attempt is abandoned; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- key_in  in  DIGIT_W  encoded key; nonzero = key held.
- relock  in  1  return from UNLOCKED to ARMED.
- clear_code  in  1  in UNLOCKED only: erase code and return to PROGRAM.
- unlock  out  1  high while in UNLOCKED.
- locked_out  out  1  high while in LOCKOUT.
- programmed  out  1  high when a code is stored (ARMED, UNLOCKED or LOCKOUT).
- digit_count  out  $clog2(CODE_LEN+1)  digits accepted in the current program or attempt sequence.
- fail_count  out  $clog2(MAX_FAILS+1)  consecutive failed attempts.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset (any state, mid-operation included):
  - state = PROGRAM; all code registers = 0; idx = 0; fails = 0; timers = 0; mismatch = 0; key_idle = 1.
  - All outputs 0.
- Press detection:
  - press = (key_in != 0) && key_idle.
  - key_idle is registered: cleared on a press, set on any cycle where key_in == 0, tracked in every state.
  - A key held for N cycles produces exactly one press.
  - A direct change from one nonzero value to another (no 0 in between) is not a press.
- All outputs decode registered state or counters. A press sampled at edge N is reflected in the outputs from cycle N+1 onward.
- PROGRAM:
  - On press: code[idx] = key_in; idx increments.
  - The press that fills the last digit sets idx = 0 and moves to ARMED.
  - relock and clear_code are ignored. The timeout does not apply.
- ARMED:
  - On press: mismatch |= (key_in != code[idx]); idx increments.
  - On the CODE_LEN-th press, using the mismatch value that includes this digit:
    - No mismatch: go to UNLOCKED; fails = 0.
    - Mismatch and fails+1 == MAX_FAILS: go to LOCKOUT; timer = LOCKOUT_CYCLES-1; fails = MAX_FAILS.
    - Otherwise: fails increments; stay in ARMED.
    - In every case idx = 0 and mismatch = 0.
  - Inter-digit timeout (TIMEOUT_CYCLES > 0):
    - While idx != 0, the idle counter counts cycles without a press; a press resets it to 0.
    - When it reaches TIMEOUT_CYCLES: idx = 0, mismatch = 0, fails unchanged.
    - A press in the same cycle as expiry wins; the timeout does not fire.
- UNLOCKED:
  - Presses are ignored.
  - relock: go to ARMED.
  - clear_code: all code registers = 0; go to PROGRAM. clear_code wins if asserted together with relock.
- LOCKOUT:
  - Presses, relock and clear_code are ignored.
  - The timer decrements each cycle. At timer == 0: go to ARMED; fails = 0.
  - Total time in LOCKOUT is exactly LOCKOUT_CYCLES cycles.
- Output decode:
  - programmed = (state != PROGRAM).
  - digit_count = idx; it is 0 in UNLOCKED and LOCKOUT.
- Any value except 0 is a legal digit, including repeated digits.

Test Plan:
- Program with reset, then keys 3,5,7,9, each followed by 0 -> programmed=1 in the cycle after the 4th press; digit_count shows 1,2,3 then 0.
- Enter 3,5,7,9 -> unlock=1 from the cycle after the 4th press; fail_count=0. Then pulse relock -> unlock=0; state is ARMED.
- Hold key 5 for 10 cycles during entry -> digit_count advances by exactly 1. Key 3 changing directly to 5 with no 0 in between -> no second press counted.
- Enter 3 wrong attempts (e.g. 1,1,1,1) with defaults -> fail_count goes 1, 2; then locked_out=1 for exactly 16 cycles with presses ignored; then locked_out=0 and fail_count=0.
- Press 3, then idle for 64 cycles -> digit_count returns to 0 and fail_count is unchanged. Then 3,5,7,9 -> unlock=1.
- In UNLOCKED, assert clear_code together with relock -> programmed=0 and unlock=0; new code 2,2,4,4 then accepted. Assert reset mid-attempt -> all outputs 0 and state PROGRAM.
